gate_equiv_sequencer: RTL and testbench

//   Sequencer for the two-implementation logic-gate datapath (structural vs

---
 rtl/gate_equiv_sequencer_if.sv | 24 ++
 rtl/gate_equiv_sequencer.sv | 93 +++++++++
 tb/tb_gate_equiv_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/gate_equiv_sequencer_if.sv
// gate_equiv_sequencer_if: start/result/status bundle between the sequencer and the gate pair under test
interface gate_equiv_sequencer_if #(
  parameter int N_IN  = 2,
  parameter int CNT_W = 8
);
  logic             start;
  logic [N_IN-1:0]  vec;
  logic             res_a;
  logic             res_b;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [N_IN-1:0]  first_err_vec;
  logic             first_err_valid;
  modport master (
    output start, res_a, res_b,
    input  vec, busy, done, pass, err_cnt, first_err_vec, first_err_valid
  );
  modport slave (
    input  start, res_a, res_b,
    output vec, busy, done, pass, err_cnt, first_err_vec, first_err_valid
  );
endinterface

// File: rtl/gate_equiv_sequencer.sv
// gate_equiv_sequencer: sweeps all input vectors over two gate implementations and tallies output mismatches
// Optional STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module gate_equiv_sequencer #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input logic                   clk,
  input logic                   reset,
  gate_equiv_sequencer_if.slave bus
);
  localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_CHECK, S_DONE} state_t;
  state_t           state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d, fev_q, fev_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic             pass_q, pass_d, fevv_q, fevv_d;
  logic             mismatch, stop;
  assign mismatch = bus.res_a ^ bus.res_b;
`ifdef STOP_ON_FAIL_EN
  assign stop = mismatch;
`else
  assign stop = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      fev_q   <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      fevv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      fev_q   <= fev_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      fevv_q  <= fevv_d;
    end
  end
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    fev_d   = fev_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    fevv_d  = fevv_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (bus.start) begin
        state_d = S_APPLY;
        vec_d   = '0;
        fev_d   = '0;
        err_d   = '0;
        pass_d  = 1'b0;
        fevv_d  = 1'b0;
      end
      S_APPLY: begin
        state_d = SETTLE == 0 ? S_CHECK : S_SETTLE;
        cnt_d   = SW'(SETTLE > 0 ? SETTLE - 1 : 0);
      end
      S_SETTLE: begin
        state_d = cnt_q == '0 ? S_CHECK : S_SETTLE;
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      end
      S_CHECK: begin
        err_d  = mismatch && err_q != '1 ? err_q + 1'b1 : err_q;
        fev_d  = mismatch && !fevv_q ? vec_q : fev_q;
        fevv_d = fevv_q | mismatch;
        // vec saturates at all-ones; a stop-on-fail exit keeps the failing vector
        if (vec_q == '1 || stop) begin
          state_d = S_DONE;
          pass_d  = !(fevv_q | mismatch);
        end else begin
          state_d = S_APPLY;
          vec_d   = vec_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign bus.vec             = vec_q;
  assign bus.busy            = state_q == S_APPLY || state_q == S_SETTLE || state_q == S_CHECK;
  assign bus.done            = state_q == S_DONE;
  assign bus.pass            = pass_q;
  assign bus.err_cnt         = err_q;
  assign bus.first_err_vec   = fev_q;
  assign bus.first_err_valid = fevv_q;
endmodule

// File: tb/tb_gate_equiv_sequencer.sv
// tb_gate_equiv_sequencer: directed vector table plus reset/relaunch sequences for the gate sequencer
module tb_gate_equiv_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   total = 0, bad = 0;
  int   mode = 0;
  always #5 clk = ~clk;
  gate_equiv_sequencer_if #(.N_IN(2), .CNT_W(8)) b2();
  gate_equiv_sequencer_if #(.N_IN(3), .CNT_W(2)) b3();
  gate_equiv_sequencer #(.N_IN(2), .SETTLE(1), .CNT_W(8)) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));
  gate_equiv_sequencer #(.N_IN(3), .SETTLE(0), .CNT_W(2)) dut3 (.clk(clk), .reset(reset), .bus(b3.slave));
  logic and_struct;
  assign and_struct = ~(~(b2.vec[1] & b2.vec[0]));
  assign b2.res_a = &b2.vec;
  assign b2.res_b = (mode == 1 || (mode == 2 && b2.vec == 2'b10)) ? ~and_struct : and_struct;
  assign b3.res_a = |b3.vec;
  assign b3.res_b = ~(|b3.vec);
  typedef struct {
    int         mode;
    int         rp;
    int         edges;
    logic [7:0] err;
    logic       pass;
    logic [1:0] fev;
    logic       fevv;
    logic [1:0] vec;
  } vec_t;
  vec_t tbl[4];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic sweep2(input int rp, output int e);
    @(posedge clk); #1 b2.start = 1'b1;
    @(posedge clk); #1 b2.start = 1'b0;
    chk("busy_after_start", b2.busy, 1);
    e = 0;
    while (e < 100) begin
      @(posedge clk); #1;
      e++;
      b2.start = (e + 1 == rp);
      if (b2.done) break;
    end
    b2.start = 1'b0;
  endtask
  initial begin
    int e;
    tbl[0] = '{0, 0, 12, 8'd0, 1'b1, 2'b00, 1'b0, 2'b11};
`ifdef STOP_ON_FAIL_EN
    tbl[1] = '{1, 0, 3,  8'd1, 1'b0, 2'b00, 1'b1, 2'b00};
    tbl[2] = '{2, 0, 9,  8'd1, 1'b0, 2'b10, 1'b1, 2'b10};
`else
    tbl[1] = '{1, 0, 12, 8'd4, 1'b0, 2'b00, 1'b1, 2'b11};
    tbl[2] = '{2, 0, 12, 8'd1, 1'b0, 2'b10, 1'b1, 2'b11};
`endif
    tbl[3] = '{0, 5, 12, 8'd0, 1'b1, 2'b00, 1'b0, 2'b11};
    b2.start = 1'b0;
    b3.start = 1'b0;
    reset = 1'b1;
    #12;
    chk("rst_vec", b2.vec, 0);
    chk("rst_busy_done", {b2.busy, b2.done, b2.pass}, 0);
    chk("rst_err", {b2.err_cnt, b2.first_err_vec, b2.first_err_valid}, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].mode;
      sweep2(tbl[i].rp, e);
      chk($sformatf("t%0d_edges", i), e, tbl[i].edges);
      chk($sformatf("t%0d_done", i), {b2.done, b2.busy}, 2'b10);
      chk($sformatf("t%0d_err", i), b2.err_cnt, tbl[i].err);
      chk($sformatf("t%0d_pass", i), b2.pass, tbl[i].pass);
      chk($sformatf("t%0d_fev", i), b2.first_err_vec, tbl[i].fev);
      chk($sformatf("t%0d_fevv", i), b2.first_err_valid, tbl[i].fevv);
      chk($sformatf("t%0d_vec", i), b2.vec, tbl[i].vec);
    end
    mode = 1;
    sweep2(0, e);
    b2.start = 1'b1;
    @(posedge clk); #1 b2.start = 1'b0;
    chk("relaunch_state", {b2.done, b2.busy}, 2'b01);
    chk("relaunch_clear", {b2.err_cnt, b2.first_err_valid, b2.vec}, 0);
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy_done", {b2.busy, b2.done}, 0);
    chk("abort_vec_err", {b2.vec, b2.err_cnt}, 0);
    #1 reset = 1'b0;
    mode = 0;
    sweep2(0, e);
    chk("clean_edges", e, 12);
    chk("clean_result", {b2.pass, b2.err_cnt, b2.first_err_valid}, {1'b1, 8'd0, 1'b0});
    @(posedge clk); #1 b3.start = 1'b1;
    @(posedge clk); #1 b3.start = 1'b0;
    e = 0;
    while (e < 100) begin
      @(posedge clk); #1;
      e++;
      if (b3.done) break;
    end
`ifdef STOP_ON_FAIL_EN
    chk("sat_edges", e, 2);
    chk("sat_err", b3.err_cnt, 1);
`else
    chk("sat_edges", e, 16);
    chk("sat_err", b3.err_cnt, 3);
`endif
    chk("sat_pass", b3.pass, 0);
    chk("sat_fev", {b3.first_err_valid, b3.first_err_vec}, 4'b1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
